mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (read-only) and data port share
// a single-cycle synchronous memory. Data port wins ties unless the fetch port
// has been denied STARVE_MAX consecutive cycles. Read data returns one cycle
// after the grant and is steered to the port that owned the read.
module mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              dm_req,
    input  logic [3:0]        dm_we,
    input  logic [31:0]       dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } owner_t;

    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             starved;
    logic [31:0]      if_rdata_q;
    logic [31:0]      dm_rdata_q;

    // Byte-offset and above-window address bits are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                dm_addr[31:ADDR_W+2], dm_addr[1:0]};

    assign starved = (starve_cnt == CNT_W'(STARVE_MAX));

    // Grant selection: lone requester wins, data port wins ties unless fetch is starved.
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (!rst) begin
            if (if_req && (!dm_req || starved)) begin
                if_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end
        end
    end

    // Memory request mux driven by whichever port holds the grant.
    always_comb begin
        mem_en    = if_gnt | dm_gnt;
        mem_addr  = dm_gnt ? dm_addr[ADDR_W+1:2] : if_addr[ADDR_W+1:2];
        mem_we    = dm_gnt ? dm_we    : 4'b0000;
        mem_wdata = dm_gnt ? dm_wdata : '0;
    end

    // Starvation counter and one-entry response-owner register.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            owner      <= OWN_NONE;
        end else begin
            if (if_req && !if_gnt) begin
                if (!starved) begin
                    starve_cnt <= starve_cnt + 1'b1;
                end
            end else begin
                starve_cnt <= '0;
            end

            if (if_gnt) begin
                owner <= OWN_IF;
            end else if (dm_gnt && (dm_we == 4'b0000)) begin
                owner <= OWN_DM;
            end else begin
                owner <= OWN_NONE;
            end
        end
    end

    // Read data capture: each port keeps its last returned word.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            if (owner == OWN_IF) begin
                if_rdata_q <= mem_rdata;
            end
            if (owner == OWN_DM) begin
                dm_rdata_q <= mem_rdata;
            end
        end
    end

    // Response valid is the owner state, suppressed while reset is held;
    // rdata shows memory data directly in the valid cycle, then holds it.
    always_comb begin
        if_rvalid = !rst && (owner == OWN_IF);
        dm_rvalid = !rst && (owner == OWN_DM);
        if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
        dm_rdata  = dm_rvalid ? mem_rdata : dm_rdata_q;
    end

endmodule
